irq_ctrl: RTL and testbench

Interrupt controller for the 10-bit-PC single-cycle CPU. It captures rising edges on four external request lines, applies a mask, a global enable and fixed priority, and sequences one interrupt entry at a time. During the entry cycle the CPU control unit pushes the PC onto the return stack and loads the PC with the vector. The block sits beside the control unit and returns to idle on the CPU's return-from-interrupt indication.

---
 rtl/irq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_irq_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl
// Interrupt controller for the 10-bit-PC single-cycle CPU. Four asynchronous
// request lines are synchronised and edge-detected into pending flags. A mask,
// a global enable and fixed lowest-index-wins priority select one source. The
// controller then sequences a single one-cycle entry strobe and waits for the
// CPU's return-from-interrupt before it accepts the next entry.
//
// Ports:
//   clk        in   1    system clock, rising edge
//   reset      in   1    asynchronous active-high reset, clears all state
//   irq        in   4    external requests (asynchronous), rising edge = event
//   mask_we    in   1    load mask from mask_in
//   mask_in    in   4    mask value, bit=1 enables the source
//   clr_we     in   1    clear the pending bits selected by clr_in
//   clr_in     in   4    pending-clear vector
//   ei         in   1    set global enable
//   di         in   1    clear global enable (wins over ei)
//   busy       in   1    CPU push/pop in progress, blocks a new entry decision
//   reti       in   1    return-from-interrupt executed this cycle
//   take       out  1    entry strobe: push PC and load vector this cycle
//   vector     out  PCW  entry address, valid while take=1
//   active_id  out  2    source being serviced
//   in_service out  1    high while in TAKE or SERVICE
//   pending    out  4    pending flags
//   gie        out  1    global interrupt enable
module irq_ctrl #(
  parameter int             PCW        = 10,
  parameter logic [PCW-1:0] VEC_BASE   = 10'd1000,
  parameter int             VEC_STRIDE = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     irq,
  input  logic           mask_we,
  input  logic [3:0]     mask_in,
  input  logic           clr_we,
  input  logic [3:0]     clr_in,
  input  logic           ei,
  input  logic           di,
  input  logic           busy,
  input  logic           reti,
  output logic           take,
  output logic [PCW-1:0] vector,
  output logic [1:0]     active_id,
  output logic           in_service,
  output logic [3:0]     pending,
  output logic           gie
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_n;
  logic [3:0]     s1_r;
  logic [3:0]     s2_r;
  logic [3:0]     s3_r;
  logic [3:0]     mask_r;
  logic [3:0]     edge_s;
  logic [3:0]     elig_s;
  logic [3:0]     win_mask_s;
  logic [1:0]     win_s;
  logic           go_s;
  logic [3:0]     clr_s;
  logic [3:0]     pending_n;
  logic           gie_n;
  logic [PCW-1:0] vector_n;

  // Two-flop synchroniser plus history flop per request line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_r <= 4'b0000;
      s2_r <= 4'b0000;
      s3_r <= 4'b0000;
    end else begin
      s1_r <= irq;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign edge_s = s2_r & ~s3_r;
  assign elig_s = pending & mask_r;

  // Fixed priority: the lowest eligible index wins.
  always_comb begin
    win_s      = 2'd0;
    win_mask_s = 4'b0000;
    if (elig_s[0]) begin
      win_s      = 2'd0;
      win_mask_s = 4'b0001;
    end else if (elig_s[1]) begin
      win_s      = 2'd1;
      win_mask_s = 4'b0010;
    end else if (elig_s[2]) begin
      win_s      = 2'd2;
      win_mask_s = 4'b0100;
    end else if (elig_s[3]) begin
      win_s      = 2'd3;
      win_mask_s = 4'b1000;
    end else begin
      win_s      = 2'd0;
      win_mask_s = 4'b0000;
    end
  end

  // Next-state logic; go_s marks the IDLE->TAKE entry decision.
  always_comb begin
    state_n = state_r;
    go_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (gie && (|elig_s) && !busy) begin
          state_n = TAKE;
          go_s    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      TAKE: begin
        state_n = SERVICE;
      end
      SERVICE: begin
        if (reti) begin
          state_n = IDLE;
        end else begin
          state_n = SERVICE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Pending/enable update: a new edge beats a simultaneous clear, and the
  // entry decision beats ei, while reti in SERVICE beats ei/di.
  always_comb begin
    clr_s     = (clr_we ? clr_in : 4'b0000) | (go_s ? win_mask_s : 4'b0000);
    pending_n = (pending & ~clr_s) | edge_s;
    vector_n  = VEC_BASE + (PCW'(VEC_STRIDE) * PCW'(win_s));
    if (go_s) begin
      gie_n = 1'b0;
    end else if ((state_r == SERVICE) && reti) begin
      gie_n = 1'b1;
    end else if (di) begin
      gie_n = 1'b0;
    end else if (ei) begin
      gie_n = 1'b1;
    end else begin
      gie_n = gie;
    end
  end

  // State, flags and registered outputs; active_id/vector freeze after entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      pending    <= 4'b0000;
      gie        <= 1'b0;
      mask_r     <= 4'b0000;
      take       <= 1'b0;
      in_service <= 1'b0;
      active_id  <= 2'd0;
      vector     <= '0;
    end else begin
      state_r    <= state_n;
      pending    <= pending_n;
      gie        <= gie_n;
      take       <= (state_n == TAKE);
      in_service <= (state_n != IDLE);
      if (mask_we) begin
        mask_r <= mask_in;
      end else begin
        mask_r <= mask_r;
      end
      if (go_s) begin
        active_id <= win_s;
        vector    <= vector_n;
      end else begin
        active_id <= active_id;
        vector    <= vector;
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl
// Directed scenarios with literal expectations followed by randomized
// stimulus. A behavioural model (sample history queue, pending set, phase
// counter) predicts the outputs of two instances: default parameters and a
// base of 1020 that makes vectors wrap.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       clr_we;
  logic [3:0] clr_in;
  logic       ei;
  logic       di;
  logic       busy;
  logic       reti;

  logic       take,  take2;
  logic [9:0] vector, vector2;
  logic [1:0] active_id, active_id2;
  logic       in_service, in_service2;
  logic [3:0] pending, pending2;
  logic       gie, gie2;

  int checks = 0;
  int errors = 0;

  irq_ctrl dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .clr_we(clr_we), .clr_in(clr_in), .ei(ei), .di(di), .busy(busy), .reti(reti),
    .take(take), .vector(vector), .active_id(active_id), .in_service(in_service),
    .pending(pending), .gie(gie)
  );

  irq_ctrl #(.PCW(10), .VEC_BASE(10'd1020), .VEC_STRIDE(4)) dut2 (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .clr_we(clr_we), .clr_in(clr_in), .ei(ei), .di(di), .busy(busy), .reti(reti),
    .take(take2), .vector(vector2), .active_id(active_id2), .in_service(in_service2),
    .pending(pending2), .gie(gie2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] samp[$] = '{4'd0, 4'd0, 4'd0};
  logic [3:0] m_pend = 4'd0;
  logic [3:0] m_mask = 4'd0;
  logic       m_gie  = 1'b0;
  int         m_phase = 0;   // 0 idle, 1 entry cycle, 2 servicing
  int         m_id    = 0;

  task automatic model_step();
    logic [3:0] ev, elig, nxt;
    logic       decide;
    int         win;
    if (reset) begin
      samp    = '{4'd0, 4'd0, 4'd0};
      m_pend  = 4'd0;
      m_mask  = 4'd0;
      m_gie   = 1'b0;
      m_phase = 0;
      m_id    = 0;
    end else begin
      // event = level two samples ago high and three samples ago low
      ev     = samp[samp.size()-2] & ~samp[samp.size()-3];
      elig   = m_pend & m_mask;
      decide = (m_phase == 0) && m_gie && (elig != 4'd0) && !busy;
      win    = 0;
      for (int i = 3; i >= 0; i--) if (elig[i]) win = i;
      nxt = m_pend;
      if (clr_we) nxt = nxt & ~clr_in;
      if (decide) nxt[win] = 1'b0;
      nxt = nxt | ev;
      if (decide) m_gie = 1'b0;
      else if (m_phase == 2 && reti) m_gie = 1'b1;
      else if (di) m_gie = 1'b0;
      else if (ei) m_gie = 1'b1;
      if (decide) m_id = win;
      if (m_phase == 0 && decide) m_phase = 1;
      else if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2 && reti) m_phase = 0;
      if (mask_we) m_mask = mask_in;
      m_pend = nxt;
      samp.push_back(irq);
      if (samp.size() > 4) void'(samp.pop_front());
    end
  endtask

  // Advance the model at each edge and compare both instances just after it.
  always @(posedge clk) begin
    logic [9:0] ev1, ev2;
    model_step();
    #1;
    ev1 = 10'(1000 + m_id * 4);
    ev2 = 10'(1020 + m_id * 4);
    chk("m_take",       32'(take),        32'(m_phase == 1));
    chk("m_in_service", 32'(in_service),  32'(m_phase != 0));
    chk("m_pending",    32'(pending),     32'(m_pend));
    chk("m_gie",        32'(gie),         32'(m_gie));
    chk("m_take2",      32'(take2),       32'(m_phase == 1));
    chk("m_in_service2",32'(in_service2), 32'(m_phase != 0));
    chk("m_pending2",   32'(pending2),    32'(m_pend));
    chk("m_gie2",       32'(gie2),        32'(m_gie));
    if (m_phase != 0) begin
      chk("m_active_id",  32'(active_id),  32'(m_id));
      chk("m_active_id2", 32'(active_id2), 32'(m_id));
    end
    if (m_phase == 1) begin
      chk("m_vector",  32'(vector),  32'(ev1));
      chk("m_vector2", 32'(vector2), 32'(ev2));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    mask_we = 1'b0;
    clr_we  = 1'b0;
    ei      = 1'b0;
    di      = 1'b0;
    reti    = 1'b0;
  endtask

  task automatic wait_take();
    int n = 0;
    while (take !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("wait_take", 32'(take), 32'd1);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; irq = 4'd0; mask_we = 1'b0; mask_in = 4'd0; clr_we = 1'b0;
    clr_in = 4'd0; ei = 1'b0; di = 1'b0; busy = 1'b0; reti = 1'b0;
    tick(); tick();
    chk("rst_take", 32'(take), 32'd0);
    chk("rst_gie",  32'(gie),  32'd0);
    reset = 1'b0;
    tick();

    // basic entry of source 2
    mask_we = 1'b1; mask_in = 4'b0100; ei = 1'b1; tick();
    irq = 4'b0100; tick();
    irq = 4'b0000; tick();
    chk("lat_pend_early", 32'(pending), 32'd0);
    tick();
    chk("lat_pend", 32'(pending), 32'b0100);
    chk("lat_take0", 32'(take), 32'd0);
    tick();
    chk("basic_take", 32'(take), 32'd1);
    chk("basic_vec", 32'(vector), 32'd1008);
    chk("basic_id", 32'(active_id), 32'd2);
    chk("basic_gie", 32'(gie), 32'd0);
    chk("basic_pend", 32'(pending), 32'd0);
    tick();
    chk("basic_take_once", 32'(take), 32'd0);
    chk("basic_service", 32'(in_service), 32'd1);
    reti = 1'b1; tick();
    chk("basic_idle", 32'(in_service), 32'd0);
    chk("basic_gie_back", 32'(gie), 32'd1);

    // priority and freeze
    mask_we = 1'b1; mask_in = 4'hF; tick();
    irq = 4'b1010; tick();
    irq = 4'b0000;
    wait_take();
    chk("prio_vec", 32'(vector), 32'd1004);
    chk("prio_id", 32'(active_id), 32'd1);
    chk("prio_pend", 32'(pending), 32'b1000);
    tick();
    irq = 4'b0001; tick();
    irq = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("nonest_take", 32'(take), 32'd0);
    end
    chk("nonest_id", 32'(active_id), 32'd1);
    chk("nonest_pend", 32'(pending), 32'b1001);
    reti = 1'b1; tick();
    wait_take();
    chk("prio_vec0", 32'(vector), 32'd1000);
    tick();
    reti = 1'b1; tick();
    wait_take();
    chk("prio_vec3", 32'(vector), 32'd1012);
    chk("wrap_vec3", 32'(vector2), 32'd8);
    tick();
    reti = 1'b1; tick();

    // gie gating, then busy deferral
    di = 1'b1; tick();
    irq = 4'b0100; tick();
    irq = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("gie0_take", 32'(take), 32'd0);
    end
    chk("gie0_pend", 32'(pending), 32'b0100);
    busy = 1'b1; ei = 1'b1; tick();
    chk("busy_take_a", 32'(take), 32'd0);
    tick();
    chk("busy_take_b", 32'(take), 32'd0);
    tick();
    chk("busy_take_c", 32'(take), 32'd0);
    busy = 1'b0; tick();
    chk("busy_take_after", 32'(take), 32'd1);
    chk("busy_vec", 32'(vector), 32'd1008);
    tick();
    reti = 1'b1; tick();

    // masked source stays pending without entry
    mask_we = 1'b1; mask_in = 4'b1110; tick();
    irq = 4'b0001; tick();
    irq = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mask_take", 32'(take), 32'd0);
    end
    chk("mask_pend", 32'(pending), 32'b0001);
    clr_we = 1'b1; clr_in = 4'b0001; tick();
    chk("clr_pend", 32'(pending), 32'd0);

    // set beats a simultaneous clear
    mask_we = 1'b1; mask_in = 4'b0000; tick();
    irq = 4'b0010; tick();
    irq = 4'b0000; tick();
    clr_we = 1'b1; clr_in = 4'b0010; tick();
    chk("setwins_pend", 32'(pending), 32'b0010);
    clr_we = 1'b1; clr_in = 4'b0010; tick();
    chk("clr2_pend", 32'(pending), 32'd0);

    // ei+di, reti in IDLE
    ei = 1'b1; di = 1'b1; tick();
    chk("eidi_gie", 32'(gie), 32'd0);
    ei = 1'b1; tick();
    chk("ei_gie", 32'(gie), 32'd1);
    reti = 1'b1; tick();
    chk("reti_idle_svc", 32'(in_service), 32'd0);
    chk("reti_idle_take", 32'(take), 32'd0);

    // held request yields exactly one entry
    mask_we = 1'b1; mask_in = 4'hF; tick();
    irq = 4'b0100; cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (take === 1'b1) cnt++;
      if (in_service === 1'b1 && take !== 1'b1) reti = 1'b1;
    end
    chk("held_one_entry", 32'(cnt), 32'd1);
    irq = 4'b0000; tick(); tick();

    // reset in the middle of SERVICE
    irq = 4'b0001; tick();
    irq = 4'b0000;
    wait_take();
    tick();
    chk("pre_rst_svc", 32'(in_service), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_take", 32'(take), 32'd0);
    chk("arst_svc", 32'(in_service), 32'd0);
    chk("arst_pend", 32'(pending), 32'd0);
    chk("arst_gie", 32'(gie), 32'd0);
    chk("arst_id", 32'(active_id), 32'd0);
    tick();
    reset = 1'b0; tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      irq     = irq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      mask_we = ($urandom_range(0, 15) == 0);
      mask_in = 4'($urandom);
      clr_we  = ($urandom_range(0, 15) == 0);
      clr_in  = 4'($urandom);
      ei      = ($urandom_range(0, 7) == 0);
      di      = ($urandom_range(0, 15) == 0);
      busy    = ($urandom_range(0, 3) == 0);
      reti    = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
